// File: rtl/panel_pkg.sv
// Shared constants, FSM encoding and vector types for the 5x7 LED matrix panel.
// Reused by the column-scan engine, the column multiplexers and the text renderer.
package panel_pkg;

    localparam int COLS  = 5;
    localparam int ROWS  = 7;
    localparam int COL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        GAP  = 2'd2
    } scan_state_t;

    typedef logic [COL_W-1:0] col_idx_t;
    typedef logic [COLS-1:0]  col_vec_t;
    typedef logic [ROWS-1:0]  row_vec_t;
    typedef row_vec_t [COLS-1:0] frame_t;

    localparam col_idx_t LAST_COL = 3'd4;

    function automatic col_vec_t col_onehot(input col_idx_t idx);
        col_vec_t oh;
        oh = {COLS{1'b0}};
        for (int i = 0; i < COLS; i++) begin
            oh[i] = (idx == col_idx_t'(i));
        end
        return oh;
    endfunction

    function automatic col_idx_t next_col(input col_idx_t idx);
        return (idx == LAST_COL) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Per-column dwell counter: counts 0..DWELL_CYCLES-1 while enabled and wraps,
// flagging the last count so the scan engine knows when to leave the column.
module dwell_timer #(
    parameter int DWELL_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    assign tc = (count_r == LAST);

    // dwell counter register; clear has priority over counting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            count_r <= tc ? {CNT_W{1'b0}} : count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/matrix_scan_controller.sv
// Column-scan engine for the 5x7 LED matrix: double-buffered frame, one-column-at-a-time
// drive with a blanking gap between columns, and tear-free commits at frame wrap.
module matrix_scan_controller
    import panel_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [COL_W-1:0] load_col,
    input  logic [ROWS-1:0]  load_data,
    input  logic             commit,
    input  logic             blank,
    output logic [COL_W-1:0] col_sel,
    output logic [COLS-1:0]  col_en,
    output logic [ROWS-1:0]  row_out,
    output logic             frame_tick
);

    scan_state_t state_r, state_s;
    col_idx_t    col_sel_r, col_s;
    col_vec_t    col_en_r, col_en_s;
    row_vec_t    row_out_r, row_s;
    frame_t      front_r, back_r, front_s;
    logic        frame_tick_r, load_ready_r;
    logic        pending_r, pending_s;
    logic        apply_s, tick_s, wr_s, tc_s;
    logic        timer_clr_s, timer_en_s;

    assign timer_en_s  = (state_r == SCAN);
    assign timer_clr_s = (state_r != SCAN) || blank;

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (timer_clr_s),
        .en   (timer_en_s),
        .tc   (tc_s)
    );

    // out-of-range columns still handshake but never land in the buffer
    assign wr_s = load_valid && load_ready_r && (load_col <= LAST_COL);

    // next state, next column, frame wrap and commit-apply decisions
    always_comb begin
        state_s = state_r;
        col_s   = col_sel_r;
        apply_s = 1'b0;
        tick_s  = 1'b0;
        case (state_r)
            IDLE: begin
                apply_s = pending_r;
                col_s   = 3'd0;
                if (blank) begin
                    state_s = IDLE;
                end else begin
                    state_s = SCAN;
                end
            end
            SCAN: begin
                if (blank) begin
                    state_s = IDLE;
                    col_s   = 3'd0;
                end else if (tc_s) begin
                    state_s = GAP;
                end else begin
                    state_s = SCAN;
                end
            end
            GAP: begin
                if (blank) begin
                    state_s = IDLE;
                    col_s   = 3'd0;
                end else begin
                    state_s = SCAN;
                    col_s   = next_col(col_sel_r);
                    if (col_sel_r == LAST_COL) begin
                        tick_s  = 1'b1;
                        apply_s = pending_r;
                    end else begin
                        tick_s  = 1'b0;
                        apply_s = 1'b0;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                col_s   = 3'd0;
            end
        endcase
    end

    // front buffer / pending update and the column drive seen after this edge
    always_comb begin
        front_s   = front_r;
        pending_s = pending_r;
        col_en_s  = {COLS{1'b0}};
        row_s     = {ROWS{1'b0}};
        if (apply_s) begin
            front_s   = back_r;
            pending_s = 1'b0;
        end else begin
            pending_s = pending_r | commit;
        end
        // row_out is taken from the post-commit front so the wrap column is never stale
        if (state_s == SCAN) begin
            col_en_s = col_onehot(col_s);
            row_s    = front_s[col_s];
        end else begin
            col_en_s = {COLS{1'b0}};
            row_s    = {ROWS{1'b0}};
        end
    end

    // FSM state and registered panel outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            col_sel_r    <= 3'd0;
            col_en_r     <= {COLS{1'b0}};
            row_out_r    <= {ROWS{1'b0}};
            frame_tick_r <= 1'b0;
            load_ready_r <= 1'b1;
            pending_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            col_sel_r    <= col_s;
            col_en_r     <= col_en_s;
            row_out_r    <= row_s;
            frame_tick_r <= tick_s;
            load_ready_r <= ~pending_s;
            pending_r    <= pending_s;
        end
    end

    // frame buffers; back is frozen while a commit is pending because load_ready is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_r <= {(COLS*ROWS){1'b0}};
            back_r  <= {(COLS*ROWS){1'b0}};
        end else begin
            front_r <= front_s;
            if (wr_s) begin
                back_r[load_col] <= load_data;
            end else begin
                back_r <= back_r;
            end
        end
    end

    assign col_sel    = col_sel_r;
    assign col_en     = col_en_r;
    assign row_out    = row_out_r;
    assign frame_tick = frame_tick_r;
    assign load_ready = load_ready_r;

endmodule

// File: doc/matrix_scan_controller.md
Name: matrix_scan_controller

Overview:
- Sequential column-scan engine for the 5x7 LED matrix panel.
- Holds a double-buffered frame: a 5-column by 7-row back buffer loaded through a valid/ready port, and a front buffer that is displayed.
- Generates the 3-bit column-select code (0..4) consumed by the per-column line multiplexers, plus a one-hot column enable and the 7-bit row pattern of the active column.
- Commits the back buffer to the front buffer only at frame boundaries, so the display never shows a torn frame.

Parameters:
- DWELL_CYCLES, 1000, clock cycles each column is lit (minimum 2).
- COLS, 5, number of columns (fixed by panel).
- ROWS, 7, number of rows per column (fixed by panel).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous reset, active-high.
- load_valid  input  1  load request for one column of the back buffer.
- load_ready  output  1  back buffer accepts writes.
- load_col  input  3  column index to write (0..4).
- load_data  input  7  row bits for that column; bit0 = row 1.
- commit  input  1  one-cycle pulse: request back-to-front transfer.
- blank  input  1  level: display off while high.
- col_sel  output  3  active column code 0..4 (mux select).
- col_en  output  5  one-hot active column; all zero during gap, idle or reset.
- row_out  output  7  row pattern of the active column; zero whenever col_en is zero.
- frame_tick  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- Clock and reset: single clock `clk`; `reset` is asynchronous and active-high.
- Reset values:
  - col_sel=0, col_en=0, row_out=0, frame_tick=0, load_ready=1.
  - Both buffers cleared, dwell counter 0, commit_pending=0, FSM in IDLE.
- All outputs are registered and change on the same edge as the FSM.
- FSM states are IDLE, SCAN and GAP.
- IDLE:
  - col_en=0, row_out=0, col_sel=0, counter=0.
  - Goes to SCAN on the first edge with blank=0, including the first edge after reset release.
- SCAN:
  - col_en=onehot(col_sel), row_out=front[col_sel].
  - Counter increments each cycle. When counter==DWELL_CYCLES-1, go to GAP and clear the counter.
- GAP:
  - Exactly 1 cycle; col_en=0, row_out=0 (anti-ghosting).
  - Next edge: col_sel = (col_sel==4) ? 0 : col_sel+1, then return to SCAN.
- Timing:
  - Column period = DWELL_CYCLES+1 cycles; frame period = 5*(DWELL_CYCLES+1).
- Frame wrap (GAP with col_sel==4):
  - frame_tick=1 in the first SCAN cycle of column 0.
  - If commit_pending, front <= back on that same wrap edge, commit_pending cleared, load_ready=1 from the next cycle.
- Load port:
  - A write occurs when load_valid & load_ready are high on a clock edge: back[load_col] <= load_data.
  - load_col > 4: the transfer is accepted and the data discarded.
  - The back buffer is not cleared by a commit, so partial updates accumulate.
- Commit:
  - A commit pulse sets commit_pending. While pending, load_ready=0 and the back buffer is frozen.
  - A commit with load_valid in the same cycle: the write completes first and is included in the commit.
  - Repeated commit pulses while pending have no additional effect.
- Blank:
  - blank=1 in any state: next edge goes to IDLE, with col_en=0, row_out=0, col_sel=0 and counter cleared.
  - A pending commit is applied on the next edge while in IDLE.
  - When blank drops, scanning restarts at column 0. frame_tick does not pulse on this restart.
- Reset mid-operation: all state returns to reset values immediately, and both buffers are cleared.

Decomposition:
- Shared package (panel_pkg):
  - constants COLS=5, ROWS=7, COL_W=3;
  - FSM state encoding (IDLE=2'd0, SCAN=2'd1, GAP=2'd2);
  - column/row vector typedefs, reused by the column multiplexers and the future text-render block.
- Sub-module dwell_timer:
  - parameterised up-counter with clear, enable and terminal-count output;
  - width = clog2(DWELL_CYCLES).

Test Plan (DWELL_CYCLES=4, so column period 5 and frame period 25):
- Reset, then release with blank=0 -> first cycle col_sel=0, col_en=5'b00001, row_out=0. Column switches after 4 cycles plus 1 gap cycle with col_en=0. frame_tick pulses every 25 cycles.
- Load columns 0..4 with 7'h01,7'h02,7'h04,7'h08,7'h10, then commit mid-frame -> load_ready drops. The old (zero) pattern persists until the wrap. In the next frame row_out equals each loaded value when col_en selects that column. load_ready returns 1 one cycle after the wrap.
- Write with load_col=6, data 7'h7F, then commit -> accepted (handshake completes) but no column shows 7'h7F.
- Commit and load_valid in the same cycle (col 2, 7'h55) -> 7'h55 appears in column 2 of the next frame. A further load_valid while pending is not accepted.
- Raise blank during SCAN of column 3 -> next cycle col_en=0, row_out=0, col_sel=0. Release -> SCAN restarts at column 0 with no frame_tick.
- Assert reset during GAP with commit pending -> all outputs 0 immediately, buffers cleared, load_ready=1, and no commit is applied.
